fir_err_monitor: RTL and testbench

//  Consumer end of the FIR datapath: takes the exact FIR output stream and the approximate
//  (fir_approx) output stream. Aligns them for differing pipeline latency, then measures

---
 rtl/fir_err_monitor_if.sv | 28 ++
 rtl/fir_err_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_fir_err_monitor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_err_monitor_if.sv
// Stream/result bundle between the FIR output sources (master) and the
// error monitor (slave). Signal names follow the monitor's port list.
interface fir_err_monitor_if #(
  parameter int DW       = 32,
  parameter int WIN_LOG2 = 8
);
  logic                     start;
  logic [2:0]               lat_diff;
  logic                     in_valid;
  logic [DW-1:0]            exact_in;
  logic [DW-1:0]            approx_in;
  logic                     busy;
  logic                     done;
  logic [WIN_LOG2:0]        err_cnt;
  logic [DW-1:0]            max_err;
  logic [DW+WIN_LOG2-1:0]   sum_err;
  logic [DW-1:0]            mean_err;

  modport master (
    output start, lat_diff, in_valid, exact_in, approx_in,
    input  busy, done, err_cnt, max_err, sum_err, mean_err
  );

  modport slave (
    input  start, lat_diff, in_valid, exact_in, approx_in,
    output busy, done, err_cnt, max_err, sum_err, mean_err
  );
endinterface

// File: rtl/fir_err_monitor.sv
// FIR error monitor: aligns the exact FIR stream to the approximate stream
// through a short delay line, then accumulates abs-error statistics over a
// window of 2**WIN_LOG2 compared samples and publishes them with a done pulse.
module fir_err_monitor #(
  parameter int DW       = 32,
  parameter int MAX_LAT  = 7,
  parameter int WIN_LOG2 = 8,
  parameter int ERR_THR  = 0
) (
  input  logic             clk,
  input  logic             Reset,
  fir_err_monitor_if.slave mon
);

  localparam int              CW        = WIN_LOG2 + 1;
  localparam int              SW        = DW + WIN_LOG2;
  localparam logic [CW-1:0]   LAST_BEAT = CW'((1 << WIN_LOG2) - 1);
  localparam logic [2:0]      MAX_LAT_C = 3'(MAX_LAT);
  localparam logic [DW-1:0]   ERR_THR_C = DW'(ERR_THR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // |sext(a) - sext(b)| computed one bit wider so the full range never overflows;
  // the magnitude always fits back into DW bits.
  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a_val,
                                             input logic [DW-1:0] b_val);
    logic [DW:0]   w_d;
    logic [DW-1:0] w_n;
    w_d = {a_val[DW-1], a_val} - {b_val[DW-1], b_val};
    w_n = ~w_d[DW-1:0] + DW'(1);
    if (w_d[DW]) begin
      abs_diff = w_n;
    end else begin
      abs_diff = w_d[DW-1:0];
    end
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;

  logic [2:0]      r_lat;
  logic [2:0]      r_fill_cnt;
  logic [CW-1:0]   r_beat_cnt;
  logic [DW-1:0]   r_dly [MAX_LAT];

  logic [SW-1:0]   r_sum;
  logic [DW-1:0]   r_max;
  logic [CW-1:0]   r_cnt;

  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_err_cnt;
  logic [DW-1:0]   r_max_err;
  logic [SW-1:0]   r_sum_err;
  logic [DW-1:0]   r_mean_err;

  logic [2:0]      w_lat_clamp;
  logic [DW-1:0]   w_exact_d;
  logic [DW-1:0]   w_abs;
  logic [SW-1:0]   w_sum_nxt;
  logic [DW-1:0]   w_max_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_shift;
  logic            w_accept;
  logic            w_start;
  logic            w_last;

  // Datapath: alignment tap selection and the per-beat statistics update.
  always_comb begin
    w_lat_clamp = (mon.lat_diff > MAX_LAT_C) ? MAX_LAT_C : mon.lat_diff;
    w_exact_d   = (r_lat == 3'd0) ? mon.exact_in : r_dly[r_lat - 3'd1];
    w_abs       = abs_diff(mon.approx_in, w_exact_d);
    w_sum_nxt   = r_sum + {{WIN_LOG2{1'b0}}, w_abs};
    w_max_nxt   = (w_abs > r_max) ? w_abs : r_max;
    w_cnt_nxt   = r_cnt + ((w_abs > ERR_THR_C) ? CW'(1) : CW'(0));
    w_shift     = mon.in_valid && ((r_state == S_FILL) || (r_state == S_ACC));
    w_accept    = mon.in_valid && (r_state == S_ACC);
    w_start     = mon.start && (r_state == S_IDLE);
    w_last      = w_accept && (r_beat_cnt == LAST_BEAT);
  end

  // Next-state logic for the measurement sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mon.start) begin
          w_state_nxt = (w_lat_clamp == 3'd0) ? S_ACC : S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (mon.in_valid && (r_fill_cnt == (r_lat - 3'd1))) begin
          w_state_nxt = S_ACC;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_ACC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Alignment delay line: shifts only on valid beats while measuring.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_dly[i] <= '0;
      end
    end else if (w_shift) begin
      r_dly[0] <= mon.exact_in;
      for (int i = 1; i < MAX_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_dly[i] <= r_dly[i];
      end
    end
  end

  // Window control: latched latency, fill and compared-beat counters.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_lat      <= 3'd0;
      r_fill_cnt <= 3'd0;
      r_beat_cnt <= '0;
    end else if (w_start) begin
      r_lat      <= w_lat_clamp;
      r_fill_cnt <= 3'd0;
      r_beat_cnt <= '0;
    end else begin
      if (mon.in_valid && (r_state == S_FILL)) begin
        r_fill_cnt <= r_fill_cnt + 3'd1;
      end
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
    end
  end

  // Running accumulators, cleared when a new window is started.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sum <= w_sum_nxt;
      r_max <= w_max_nxt;
      r_cnt <= w_cnt_nxt;
    end else begin
      r_sum <= r_sum;
      r_max <= r_max;
      r_cnt <= r_cnt;
    end
  end

  // Registered status and results; results load together with the done pulse
  // and hold until the next completed window.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_cnt  <= '0;
      r_max_err  <= '0;
      r_sum_err  <= '0;
      r_mean_err <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_FILL) || (w_state_nxt == S_ACC);
      r_done <= (w_state_nxt == S_DONE);
      if (w_last) begin
        r_err_cnt  <= w_cnt_nxt;
        r_max_err  <= w_max_nxt;
        r_sum_err  <= w_sum_nxt;
        r_mean_err <= w_sum_nxt[SW-1:WIN_LOG2];
      end
    end
  end

  assign mon.busy     = r_busy;
  assign mon.done     = r_done;
  assign mon.err_cnt  = r_err_cnt;
  assign mon.max_err  = r_max_err;
  assign mon.sum_err  = r_sum_err;
  assign mon.mean_err = r_mean_err;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Testbench for fir_err_monitor: directed table windows, multi-cycle corner
// sequences and randomized windows checked against an arithmetic model.
module tb_fir_err_monitor;
  localparam int DW       = 32;
  localparam int MAX_LAT  = 7;
  localparam int WIN_LOG2 = 2;
  localparam int ERR_THR  = 0;
  localparam int NW       = 1 << WIN_LOG2;

  logic clk = 1'b0;
  logic Reset;

  fir_err_monitor_if #(.DW(DW), .WIN_LOG2(WIN_LOG2)) u_if ();

  fir_err_monitor #(
    .DW(DW), .MAX_LAT(MAX_LAT), .WIN_LOG2(WIN_LOG2), .ERR_THR(ERR_THR)
  ) u_dut (
    .clk   (clk),
    .Reset (Reset),
    .mon   (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       lat;
    logic [3:0][31:0] ex;
    logic [3:0][31:0] ap;
    logic [2:0]       cnt;
    logic [31:0]      mx;
    logic [33:0]      sm;
    logic [31:0]      mn;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q_ex[$];
  logic [31:0] q_ap[$];
  logic [33:0] last_sm;
  vec_t        tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: compare approx beat L+j with exact beat j, plain integer arithmetic.
  function automatic void model(input int L, output logic [2:0] c,
                                output logic [31:0] mx, output logic [33:0] sm);
    longint a;
    c = '0; mx = '0; sm = '0;
    for (int j = 0; j < NW; j++) begin
      a = longint'($signed(q_ap[L+j])) - longint'($signed(q_ex[j]));
      if (a < 0) a = -a;
      sm = sm + 34'(a);
      if (a > longint'(mx)) mx = 32'(a);
      if (a > longint'(ERR_THR)) c = c + 3'd1;
    end
  endfunction

  // Drive one full window from the queues and check timing and results.
  task automatic run_window(input string tag, input logic [2:0] lat, input int gmode,
                            input bit mid_start, input logic [2:0] ec, input logic [31:0] em,
                            input logic [33:0] es, input logic [31:0] emn);
    int nb, k, cyc, dn;
    bit v;
    nb = int'(lat) + NW; k = 0; cyc = 0; dn = 0;
    u_if.start = 1'b1; u_if.lat_diff = lat; u_if.in_valid = 1'b0;
    tick();
    u_if.start = 1'b0;
    chk({tag, "/busy_on_start"}, 64'(u_if.busy), 64'd1);
    chk({tag, "/hold_on_start"}, 64'(u_if.sum_err), 64'(last_sm));
    while (k < nb && cyc < 400) begin
      case (gmode)
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(99, 0) >= 35);
        default: v = 1'b1;
      endcase
      u_if.in_valid = v;
      if (v) begin
        u_if.exact_in = q_ex[k]; u_if.approx_in = q_ap[k]; k++;
      end else begin
        u_if.exact_in = $urandom; u_if.approx_in = $urandom;
      end
      u_if.start = mid_start && (k == nb / 2);
      tick();
      cyc++;
      if (u_if.done) dn++;
    end
    u_if.in_valid = 1'b0; u_if.start = 1'b0;
    if (k < nb) begin
      n_vec++; n_err++;
      $display("FAIL %s/timeout: got %0d beats, expected %0d", tag, k, nb);
    end
    chk({tag, "/done_after_last"}, 64'(u_if.done), 64'd1);
    chk({tag, "/done_count"}, 64'(dn), 64'd1);
    chk({tag, "/err_cnt"}, 64'(u_if.err_cnt), 64'(ec));
    chk({tag, "/max_err"}, 64'(u_if.max_err), 64'(em));
    chk({tag, "/sum_err"}, 64'(u_if.sum_err), 64'(es));
    chk({tag, "/mean_err"}, 64'(u_if.mean_err), 64'(emn));
    tick();
    chk({tag, "/done_pulse"}, 64'(u_if.done), 64'd0);
    chk({tag, "/busy_idle"}, 64'(u_if.busy), 64'd0);
    last_sm = es;
  endtask

  task automatic load_tbl(input int t);
    q_ex.delete(); q_ap.delete();
    for (int i = 0; i < NW; i++) begin
      q_ex.push_back(tbl[t].ex[i]);
      q_ap.push_back(tbl[t].ap[i]);
    end
  endtask

  initial begin
    logic [2:0]  ec, lat;
    logic [31:0] em;
    logic [33:0] es;
    int          dn, mode;

    tbl[0] = '{lat: 3'd0, ex: {4{32'd100}}, ap: {4{32'd100}},
               cnt: 3'd0, mx: 32'd0, sm: 34'd0, mn: 32'd0};
    tbl[1] = '{lat: 3'd0, ex: {4{32'd0}}, ap: {32'd1, 32'hFFFF_FFFD, 32'd2, 32'd0},
               cnt: 3'd3, mx: 32'd3, sm: 34'd6, mn: 32'd1};
    tbl[2] = '{lat: 3'd0, ex: {4{32'h8000_0000}}, ap: {4{32'h7FFF_FFFF}},
               cnt: 3'd4, mx: 32'hFFFF_FFFF, sm: 34'h3_FFFF_FFFC, mn: 32'hFFFF_FFFF};
    tbl[3] = '{lat: 3'd0, ex: {4{32'h7FFF_FFFF}}, ap: {4{32'h8000_0000}},
               cnt: 3'd4, mx: 32'hFFFF_FFFF, sm: 34'h3_FFFF_FFFC, mn: 32'hFFFF_FFFF};

    Reset = 1'b1;
    u_if.start = 1'b1; u_if.lat_diff = 3'd0; u_if.in_valid = 1'b1;
    u_if.exact_in = 32'd5; u_if.approx_in = 32'd9;
    repeat (3) tick();
    chk("reset/busy", 64'(u_if.busy), 64'd0);
    chk("reset/done", 64'(u_if.done), 64'd0);
    chk("reset/err_cnt", 64'(u_if.err_cnt), 64'd0);
    chk("reset/max_err", 64'(u_if.max_err), 64'd0);
    chk("reset/sum_err", 64'(u_if.sum_err), 64'd0);
    chk("reset/mean_err", 64'(u_if.mean_err), 64'd0);
    Reset = 1'b0; u_if.start = 1'b0; u_if.in_valid = 1'b0;
    last_sm = '0;
    tick();

    // Directed table windows.
    for (int t = 0; t < 4; t++) begin
      load_tbl(t);
      run_window($sformatf("tbl%0d", t), tbl[t].lat, 0, 1'b0,
                 tbl[t].cnt, tbl[t].mx, tbl[t].sm, tbl[t].mn);
    end

    // Reset after two beats of a window discards it.
    load_tbl(1);
    u_if.start = 1'b1; u_if.lat_diff = 3'd0; tick(); u_if.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      u_if.in_valid = 1'b1; u_if.exact_in = q_ex[i]; u_if.approx_in = q_ap[i];
      tick();
    end
    Reset = 1'b1; tick(); Reset = 1'b0; u_if.in_valid = 1'b0;
    chk("rst_mid/busy", 64'(u_if.busy), 64'd0);
    chk("rst_mid/done", 64'(u_if.done), 64'd0);
    chk("rst_mid/err_cnt", 64'(u_if.err_cnt), 64'd0);
    chk("rst_mid/max_err", 64'(u_if.max_err), 64'd0);
    chk("rst_mid/sum_err", 64'(u_if.sum_err), 64'd0);
    chk("rst_mid/mean_err", 64'(u_if.mean_err), 64'd0);
    last_sm = '0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      u_if.in_valid = 1'b1; u_if.exact_in = $urandom; u_if.approx_in = $urandom;
      tick();
      if (u_if.done) dn++;
    end
    u_if.in_valid = 1'b0;
    chk("rst_mid/no_done_idle", 64'(dn), 64'd0);
    chk("rst_mid/busy_idle", 64'(u_if.busy), 64'd0);
    run_window("after_rst", 3'd0, 0, 1'b0, 3'd3, 32'd3, 34'd6, 32'd1);

    // L=2, approx is the exact ramp delayed by two beats: zero error.
    q_ex.delete(); q_ap.delete();
    for (int i = 0; i < 2 + NW; i++) begin
      q_ex.push_back(32'(i + 1));
      q_ap.push_back(32'(i - 1));
    end
    run_window("lat2_ramp", 3'd2, 0, 1'b0, 3'd0, 32'd0, 34'd0, 32'd0);

    // L=1, in_valid toggling 1010.. with a start pulse mid-window.
    q_ex.delete(); q_ap.delete();
    q_ex = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    q_ap = '{32'd999, 32'd12, 32'd15, 32'd30, 32'd47};
    run_window("toggle_midstart", 3'd1, 1, 1'b1, 3'd3, 32'd7, 34'd14, 32'd3);

    // Randomized windows against the reference model.
    for (int r = 0; r < 24; r++) begin
      lat = 3'($urandom_range(7, 0));
      mode = $urandom_range(2, 0);
      q_ex.delete(); q_ap.delete();
      for (int i = 0; i < int'(lat) + NW; i++) begin
        logic [31:0] e, a;
        logic [31:0] ext;
        ext = 32'h8000_0000;
        case (mode)
          0: begin
            e = $urandom;
            a = e + 32'($urandom_range(6, 0)) - 32'd3;
          end
          1: begin
            e = $urandom; a = $urandom;
          end
          default: begin
            e = ($urandom_range(1, 0) == 1) ? ext : ~ext;
            a = ($urandom_range(1, 0) == 1) ? ext : ~ext;
          end
        endcase
        q_ex.push_back(e);
        q_ap.push_back(a);
      end
      model(int'(lat), ec, em, es);
      run_window($sformatf("rnd%0d", r), lat, $urandom_range(2, 0),
                 1'($urandom_range(1, 0)), ec, em, es, 32'(es >> WIN_LOG2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
